axi_s_pkt_gen: RTL and testbench

AXI_S_PKT_GEN -- requirements
Module: axi_s_pkt_gen

---
 rtl/axi_s_gen_pkg.sv | 31 +++
 rtl/prbs_lfsr.sv | 48 ++++
 rtl/axi_s_pkt_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_s_pkt_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_s_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator.
//   mode_e       payload pattern encodings as seen on i_mode
//   state_e      generator FSM states
//   PRBS31_TAPS  feedback taps of x^31 + x^28 + 1 (bits 30 and 27)
//   lfsr_width() register width of the LFSR for a given stream width
// PRBS support is only built when AXIS_PKT_GEN_PRBS_EN is defined.
package axi_s_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_FIX  = 2'd1,
    MODE_PRBS = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned         PRBS_ORDER  = 31;
  localparam logic [PRBS_ORDER-1:0] PRBS31_TAPS = 31'h4800_0000;

  // The shift register is at least 31 bits so the polynomial fits; wider
  // streams shift the whole word so every output bit is a delayed PRBS bit.
  function automatic int unsigned lfsr_width(input int unsigned w);
    return (w > PRBS_ORDER) ? w : PRBS_ORDER;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR for x^31 + x^28 + 1, used by the packet generator's PRBS
// payload mode (only instantiated when AXIS_PKT_GEN_PRBS_EN is defined).
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (state cleared)
//   i_en            advance one step
//   i_load          load i_seed (all-zero seed becomes all-ones); wins over i_en
//   i_seed          seed word
//   o_state         current state, low P_WIDTH bits
module prbs_lfsr
  import axi_s_gen_pkg::*;
#(
  parameter int unsigned P_WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_load,
  input  logic [P_WIDTH-1:0] i_seed,
  output logic [P_WIDTH-1:0] o_state
);

  localparam int unsigned L = lfsr_width(P_WIDTH);

  logic [L-1:0] state_q, state_d, seed_ext;
  logic         fb;

  always_comb begin
    seed_ext = '0;
    seed_ext[P_WIDTH-1:0] = i_seed;
    // all-zero is the lock-up state of an XOR LFSR
    if (i_seed == '0) seed_ext = '1;
    fb = ^(state_q[PRBS_ORDER-1:0] & PRBS31_TAPS);
    state_d = state_q;
    if (i_load) begin
      state_d = seed_ext;
    end else if (i_en) begin
      state_d = {state_q[L-2:0], fb};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= '0;
    else          state_q <= state_d;
  end

  assign o_state = state_q[P_WIDTH-1:0];

endmodule

// File: rtl/axi_s_pkt_gen.sv
// AXI-Stream packet generator. Sends runs of fixed-length packets with a
// programmable idle gap, payload = run-wide counter, fixed word or PRBS-31.
// Configuration is captured on an accepted i_start and held for the run.
// Optional feature: define AXIS_PKT_GEN_PRBS_EN to build PRBS mode; without
// it mode 2 behaves as counter mode and no LFSR is present.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_start / i_stop       start pulse (IDLE only) / level stop request
//   i_mode, i_pkt_len, i_gap, i_pkt_num, i_last_keep, i_seed  run config
//   o_axi_s_*, i_axi_s_ready  AXI-Stream master
//   o_busy, o_done, o_pkt_cnt  status
//
// state   | meaning
// IDLE    | waiting for i_start, valid low
// SEND    | presenting beats, valid high
// GAP     | idle cycles between packets, down-counter gap_cnt_q
module axi_s_pkt_gen
  import axi_s_gen_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_LEN_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic [1:0]                i_mode,
  input  logic [P_LEN_WIDTH-1:0]    i_pkt_len,
  input  logic [P_LEN_WIDTH-1:0]    i_gap,
  input  logic [P_LEN_WIDTH-1:0]    i_pkt_num,
  input  logic [P_DATA_WIDTH/8-1:0] i_last_keep,
  input  logic [P_DATA_WIDTH-1:0]   i_seed,
  output logic [P_DATA_WIDTH-1:0]   o_axi_s_data,
  output logic [P_DATA_WIDTH/8-1:0] o_axi_s_keep,
  output logic                      o_axi_s_last,
  output logic                      o_axi_s_valid,
  input  logic                      i_axi_s_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [P_LEN_WIDTH-1:0]    o_pkt_cnt
);

  localparam int unsigned KW = P_DATA_WIDTH / 8;
  localparam logic [P_LEN_WIDTH-1:0]  ONE   = {{(P_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_DATA_WIDTH-1:0] D_ONE = {{(P_DATA_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d, mode_eff;
  logic [P_LEN_WIDTH-1:0]  len_q, len_d, gap_q, gap_d, num_q, num_d;
  logic [P_LEN_WIDTH-1:0]  beat_q, beat_d, gap_cnt_q, gap_cnt_d;
  logic [P_LEN_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d, pkt_cnt_inc, len_in, beat_nxt;
  logic [KW-1:0]           lkeep_q, lkeep_d, lkeep_in, keep_q, keep_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, busy_q, busy_d;
  logic stop_pend_q, stop_pend_d, run_end, first_last, beat_ok;

  assign beat_ok = valid_q && i_axi_s_ready;

  always_comb begin
    mode_eff = MODE_CNT;
    case (mode_e'(i_mode))
      MODE_FIX:  mode_eff = MODE_FIX;
`ifdef AXIS_PKT_GEN_PRBS_EN
      MODE_PRBS: mode_eff = MODE_PRBS;
`endif
      default:   mode_eff = MODE_CNT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    gap_d       = gap_q;
    num_d       = num_q;
    lkeep_d     = lkeep_q;
    beat_d      = beat_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    data_d      = data_q;
    keep_d      = keep_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;

    len_in      = (i_pkt_len == '0) ? ONE : i_pkt_len;
    lkeep_in    = (i_last_keep == '0) ? '1 : i_last_keep;
    first_last  = (len_q == ONE);
    beat_nxt    = beat_q + ONE;
    pkt_cnt_inc = (&pkt_cnt_q) ? pkt_cnt_q : pkt_cnt_q + ONE;
    // stop_pend_q covers i_start and i_stop in the same cycle: one packet
    run_end     = ((num_q != '0) && (pkt_cnt_inc == num_q)) || i_stop || stop_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_SEND;
          mode_d      = mode_eff;
          len_d       = len_in;
          gap_d       = i_gap;
          num_d       = i_pkt_num;
          lkeep_d     = lkeep_in;
          stop_pend_d = i_stop;
          pkt_cnt_d   = '0;
          beat_d      = '0;
          data_d      = (mode_eff == MODE_FIX) ? i_seed : '0;
          valid_d     = 1'b1;
          last_d      = (len_in == ONE);
          keep_d      = (len_in == ONE) ? lkeep_in : '1;
        end
      end
      ST_SEND: begin
        if (beat_ok) begin
          if (mode_q == MODE_CNT) data_d = data_q + D_ONE;
          if (last_q) begin
            pkt_cnt_d = pkt_cnt_inc;
            beat_d    = '0;
            if (run_end) begin
              state_d     = ST_IDLE;
              valid_d     = 1'b0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              valid_d   = 1'b0;
            end else begin
              last_d = first_last;
              keep_d = first_last ? lkeep_q : '1;
            end
          end else begin
            beat_d = beat_nxt;
            last_d = (beat_nxt == len_q - ONE);
            keep_d = (beat_nxt == len_q - ONE) ? lkeep_q : '1;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - ONE;
        if (i_stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == ONE) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          last_d  = first_last;
          keep_d  = first_last ? lkeep_q : '1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CNT;
      len_q       <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      lkeep_q     <= '0;
      beat_q      <= '0;
      gap_cnt_q   <= '0;
      pkt_cnt_q   <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      num_q       <= num_d;
      lkeep_q     <= lkeep_d;
      beat_q      <= beat_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      stop_pend_q <= stop_pend_d;
    end
  end

`ifdef AXIS_PKT_GEN_PRBS_EN
  logic [P_DATA_WIDTH-1:0] prbs_word;
  logic                    start_ok, prbs_step;

  assign start_ok  = (state_q == ST_IDLE) && i_start;
  assign prbs_step = (state_q == ST_SEND) && beat_ok;

  prbs_lfsr #(.P_WIDTH(P_DATA_WIDTH)) u_prbs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (prbs_step),
    .i_load  (start_ok),
    .i_seed  (i_seed),
    .o_state (prbs_word)
  );

  // the LFSR register itself is the payload word in PRBS mode
  assign o_axi_s_data = (mode_q == MODE_PRBS) ? prbs_word : data_q;
`else
  assign o_axi_s_data = data_q;
`endif

  assign o_axi_s_keep  = keep_q;
  assign o_axi_s_last  = last_q;
  assign o_axi_s_valid = valid_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_axi_s_pkt_gen.sv
// Self-checking bench for axi_s_pkt_gen (32-bit data, 16-bit length fields).
// Works with or without AXIS_PKT_GEN_PRBS_EN defined.
module tb_axi_s_pkt_gen;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int KW = 4;
`ifdef AXIS_PKT_GEN_PRBS_EN
  localparam bit PRBS_ON = 1'b1;
`else
  localparam bit PRBS_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, ready = 1'b1;
  logic [1:0]    mode = '0;
  logic [LW-1:0] len = '0, gap = '0, num = '0;
  logic [KW-1:0] lk = '0;
  logic [DW-1:0] seed = '0;

  logic [DW-1:0] o_data;
  logic [KW-1:0] o_keep;
  logic          o_last, o_valid, o_busy, o_done;
  logic [LW-1:0] o_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_s_pkt_gen #(.P_DATA_WIDTH(DW), .P_LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_mode(mode), .i_pkt_len(len), .i_gap(gap), .i_pkt_num(num),
    .i_last_keep(lk), .i_seed(seed),
    .o_axi_s_data(o_data), .o_axi_s_keep(o_keep), .o_axi_s_last(o_last),
    .o_axi_s_valid(o_valid), .i_axi_s_ready(ready),
    .o_busy(o_busy), .o_done(o_done), .o_pkt_cnt(o_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Run position is kept as a single beat number n; packet boundaries and
  // payload follow from n arithmetically.
  int unsigned m_len, m_gap, m_num, m_n, m_pkts, m_gap_left, m_mode, m_phase;
  bit          m_stop_pend;
  logic [KW-1:0] m_lk;
  logic [DW-1:0] m_seed, m_word;
  logic          e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [LW-1:0] e_cnt = '0;

  logic [DW-1:0] log_d[$];
  logic [KW-1:0] log_k[$];
  logic          log_l[$];
  int vcnt = 0, stab_cnt = 0;

  function automatic bit m_is_last();
    return (m_n % m_len) == (m_len - 1);
  endfunction

  function automatic logic [DW-1:0] m_data();
    case (m_mode)
      1:       return m_seed;
      2:       return m_word;
      default: return DW'(m_n);
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pkts = 0; m_n = 0;
    e_valid = 0; e_busy = 0; e_done = 0; e_cnt = '0;
  endtask

  task automatic model_step();
    bit lastb;
    bit nd;
    nd = 0;
    case (m_phase)
      0: if (start) begin
        m_len  = (len == 0) ? 1 : int'(len);
        m_gap  = gap;
        m_num  = num;
        m_lk   = (lk == '0) ? '1 : lk;
        m_seed = seed;
        m_mode = (mode == 2'd1) ? 1 : ((mode == 2'd2 && PRBS_ON) ? 2 : 0);
        m_word = (seed == '0) ? '1 : seed;
        m_n = 0; m_pkts = 0; m_stop_pend = stop; m_phase = 1;
      end
      1: if (ready) begin
        lastb = m_is_last();
        log_d.push_back(m_data());
        log_k.push_back(lastb ? m_lk : '1);
        log_l.push_back(lastb);
        m_n++;
        m_word = {m_word[30:0], m_word[30] ^ m_word[27]};
        if (lastb) begin
          if (m_pkts < 65535) m_pkts++;
          if ((m_num != 0 && m_pkts == m_num) || stop || m_stop_pend) begin
            m_phase = 0; nd = 1;
          end else if (m_gap != 0) begin
            m_phase = 2; m_gap_left = m_gap;
          end
        end
      end
      2: if (stop) begin
        m_phase = 0; nd = 1;
      end else begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = 1;
      end
      default: m_phase = 0;
    endcase
    e_valid = (m_phase == 1);
    e_busy  = (m_phase != 0);
    e_done  = nd;
    e_cnt   = LW'(m_pkts);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_keep", o_keep, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_cnt", o_cnt, 0);
    end else begin
      chk("valid", o_valid, e_valid);
      chk("busy", o_busy, e_busy);
      chk("done", o_done, e_done);
      chk("pkt_cnt", o_cnt, e_cnt);
      if (e_valid) begin
        chk("data", o_data, m_data());
        chk("keep", o_keep, m_is_last() ? m_lk : 4'hF);
        chk("last", o_last, m_is_last());
        vcnt++;
        if (o_data == 32'd1) stab_cnt++;
      end
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_start(input logic [1:0] md, input logic [LW-1:0] l, input logic [LW-1:0] g,
                           input logic [LW-1:0] n, input logic [KW-1:0] k,
                           input logic [DW-1:0] sd, input logic stp);
    mode = md; len = l; gap = g; num = n; lk = k; seed = sd; stop = stp; start = 1'b1;
    log_d.delete(); log_k.delete(); log_l.delete();
    vcnt = 0; stab_cnt = 0;
    cyc(1);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int waited;
    waited = 0;
    while (!o_done && waited < budget) begin cyc(1); waited++; end
    chk(nm, (waited < budget), 1);
  endtask

  task automatic wait_cnt(input logic [LW-1:0] v, input string nm);
    int waited;
    waited = 0;
    while (o_cnt != v && waited < 300) begin cyc(1); waited++; end
    chk(nm, (waited < 300), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("t0_valid", o_valid, 0);
    chk("t0_busy", o_busy, 0);
    chk("t0_cnt", o_cnt, 0);

    // counter, len 4, gap 2, two packets
    run_start(2'd0, 16'd4, 16'd2, 16'd2, 4'h0, 32'h0, 1'b0);
    wait_done(100, "t1_done");
    chk("t1_nbeats", log_d.size(), 8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      chk("t1_data", log_d[i], i);
      chk("t1_last", log_l[i], (i == 3 || i == 7));
    end
    chk("t1_cnt", o_cnt, 2);
    cyc(3);

    // backpressure on beat 1 of a 3-beat packet
    run_start(2'd0, 16'd3, 16'd0, 16'd1, 4'h0, 32'h0, 1'b0);
    cyc(1);
    ready = 1'b0;
    cyc(3);
    ready = 1'b1;
    wait_done(50, "t2_done");
    chk("t2_hold_cycles", stab_cnt, 4);
    chk("t2_nbeats", log_d.size(), 3);
    for (int i = 0; i < 3 && i < log_d.size(); i++) chk("t2_data", log_d[i], i);
    cyc(2);

    // single-beat packets, no gap, partial keep
    run_start(2'd0, 16'd1, 16'd0, 16'd4, 4'b0011, 32'h0, 1'b0);
    wait_done(50, "t3_done");
    chk("t3_valid_cycles", vcnt, 4);
    for (int i = 0; i < 4 && i < log_k.size(); i++) begin
      chk("t3_keep", log_k[i], 4'b0011);
      chk("t3_last", log_l[i], 1);
    end
    cyc(2);

    // unlimited run, stop in the middle of packet 5
    run_start(2'd0, 16'd8, 16'd1, 16'd0, 4'h0, 32'h0, 1'b0);
    wait_cnt(16'd4, "t4_reach4");
    cyc(4);
    stop = 1'b1;
    wait_done(100, "t4_done");
    stop = 1'b0;
    chk("t4_cnt", o_cnt, 5);
    chk("t4_nbeats", log_d.size(), 40);
    cyc(2);

    // stop during the gap
    run_start(2'd0, 16'd2, 16'd5, 16'd0, 4'h0, 32'h0, 1'b0);
    wait_cnt(16'd1, "t5_reach1");
    cyc(2);
    stop = 1'b1;
    wait_done(10, "t5_done");
    stop = 1'b0;
    chk("t5_cnt", o_cnt, 1);
    chk("t5_nbeats", log_d.size(), 2);
    cyc(2);

    // fixed word; config changes and a second start mid-run must not matter
    run_start(2'd1, 16'd2, 16'd1, 16'd2, 4'b0001, 32'hA5A5_1234, 1'b0);
    cyc(1);
    seed = 32'hDEAD_BEEF; len = 16'd7; mode = 2'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done(50, "t6_done");
    chk("t6_nbeats", log_d.size(), 4);
    for (int i = 0; i < 4 && i < log_d.size(); i++) chk("t6_data", log_d[i], 32'hA5A5_1234);
    if (log_k.size() >= 2) begin
      chk("t6_keep0", log_k[0], 4'hF);
      chk("t6_keep1", log_k[1], 4'b0001);
    end
    cyc(2);

    // start and stop together: exactly one packet
    run_start(2'd0, 16'd3, 16'd0, 16'd0, 4'h0, 32'h0, 1'b1);
    wait_done(50, "t7_done");
    chk("t7_cnt", o_cnt, 1);
    chk("t7_nbeats", log_d.size(), 3);
    cyc(2);

    // length 0 acts as 1, keep 0 acts as all-ones
    run_start(2'd0, 16'd0, 16'd0, 16'd2, 4'h0, 32'h0, 1'b0);
    wait_done(50, "t8_done");
    chk("t8_nbeats", log_d.size(), 2);
    for (int i = 0; i < 2 && i < log_k.size(); i++) begin
      chk("t8_keep", log_k[i], 4'hF);
      chk("t8_last", log_l[i], 1);
    end
    cyc(2);

    // mode 2, zero seed
    run_start(2'd2, 16'd4, 16'd0, 16'd1, 4'h0, 32'h0, 1'b0);
    wait_done(50, "t9_done");
    chk("t9_nbeats", log_d.size(), 4);
    if (log_d.size() >= 4) begin
      if (PRBS_ON) begin
        chk("t9_w0", log_d[0], 32'hFFFF_FFFF);
        chk("t9_w1", log_d[1], 32'hFFFF_FFFE);
        chk("t9_w2", log_d[2], 32'hFFFF_FFFC);
        chk("t9_w3", log_d[3], 32'hFFFF_FFF8);
      end else begin
        for (int i = 0; i < 4; i++) chk("t9_cnt_w", log_d[i], i);
      end
    end
    cyc(2);

    // mode 2, seed 1, with gaps and backpressure
    run_start(2'd2, 16'd5, 16'd1, 16'd2, 4'h0, 32'h1, 1'b0);
    cyc(2); ready = 1'b0; cyc(2); ready = 1'b1; cyc(3); ready = 1'b0; cyc(1); ready = 1'b1;
    wait_done(100, "t10_done");
    if (log_d.size() >= 2) chk("t10_w1", log_d[1], PRBS_ON ? 32'h2 : 32'h1);
    cyc(2);

    // reset mid-beat, then a fresh run restarts the counter
    run_start(2'd0, 16'd8, 16'd0, 16'd0, 4'h0, 32'h0, 1'b0);
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t11_valid", o_valid, 0);
    chk("t11_data", o_data, 0);
    chk("t11_last", o_last, 0);
    chk("t11_busy", o_busy, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    run_start(2'd0, 16'd2, 16'd0, 16'd1, 4'h0, 32'h0, 1'b0);
    wait_done(50, "t11_done");
    chk("t11_nbeats", log_d.size(), 2);
    if (log_d.size() >= 2) begin
      chk("t11_d0", log_d[0], 0);
      chk("t11_d1", log_d[1], 1);
    end
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
